// File: rtl/inst_page_buffer.sv
// Instruction page buffer: captures a 4 KiB page refill from the fetch AXI
// read channel into an inferred block RAM and serves tagged instruction reads.
module inst_page_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int PAGE_BITS  = 12,
    parameter int BURST_LEN  = 32
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    FILL_START,
    input  logic [31-PAGE_BITS:0]   FILL_PAGE,
    input  logic                    FILL_VALID,
    input  logic [DATA_WIDTH-1:0]   FILL_DATA,
    input  logic [1:0]              FILL_RESP,
    input  logic                    FILL_LAST,
    output logic                    FILL_BUSY,
    output logic                    FILL_DONE,
    input  logic                    PC_VALID,
    input  logic [31:0]             PC,
    input  logic                    STALL,
    output logic                    HIT,
    output logic                    INST_VALID,
    output logic [DATA_WIDTH-1:0]   INST,
    output logic [31:0]             INST_PC,
    output logic                    INST_ERR
);

    localparam int AW    = PAGE_BITS - 2;
    localparam int WORDS = 1 << AW;
    localparam int TW    = 32 - PAGE_BITS;
    localparam int BW    = $clog2(BURST_LEN);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

    typedef enum logic [1:0] {S_EMPTY, S_FILL, S_READY} state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tag_q;
    logic                    tag_valid_q;
    logic                    page_err_q;
    logic [AW-1:0]           wptr_q;
    logic                    fill_done_q;
    logic                    inst_valid_q;
    logic [31:0]             inst_pc_q;
    logic                    inst_err_q;
    logic                    rd_live_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   mem [WORDS];

    logic beat_accept;
    logic last_beat;
    logic hit;

    // A start in the same cycle as a beat discards the beat.
    assign beat_accept = (state_q == S_FILL) && FILL_VALID && !FILL_START;
    assign last_beat   = beat_accept && (&wptr_q);

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (FILL_START) begin
            state_d = S_FILL;
        end else if (last_beat) begin
            state_d = S_READY;
        end
    end

    // Output logic
    always_comb begin
        FILL_BUSY = (state_q == S_FILL);
        FILL_DONE = fill_done_q;
        hit       = PC_VALID && (state_q == S_READY) && tag_valid_q &&
                    (PC[31:PAGE_BITS] == tag_q);
        HIT       = hit;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            page_err_q  <= 1'b0;
            wptr_q      <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= last_beat;
            if (FILL_START) begin
                tag_q       <= FILL_PAGE;
                tag_valid_q <= 1'b0;
                page_err_q  <= 1'b0;
                wptr_q      <= '0;
            end else if (beat_accept) begin
                wptr_q <= wptr_q + 1'b1;
                // Bus error, or RLAST not on the burst boundary, poisons the page.
                if ((FILL_RESP != 2'b00) || (FILL_LAST != (wptr_q[BW-1:0] == BURST_LAST))) begin
                    page_err_q <= 1'b1;
                end
                if (&wptr_q) begin
                    tag_valid_q <= 1'b1;
                end
            end
        end
    end

    // Page RAM: write port for refill, registered read port with enable.
    always_ff @(posedge CLK) begin
        if (beat_accept) begin
            mem[wptr_q] <= FILL_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!STALL) begin
            rd_data_q <= mem[PC[PAGE_BITS-1:2]];
        end
    end

    // A flush clears INST_VALID even while the read side is stalled.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            inst_valid_q <= 1'b0;
            inst_pc_q    <= '0;
            inst_err_q   <= 1'b0;
            rd_live_q    <= 1'b0;
        end else begin
            if (FILL_START) begin
                inst_valid_q <= 1'b0;
            end else if (!STALL) begin
                inst_valid_q <= hit;
            end
            if (!STALL) begin
                inst_pc_q  <= PC;
                inst_err_q <= hit && (page_err_q || (PC[1:0] != 2'b00));
                rd_live_q  <= 1'b1;
            end
        end
    end

    // RAM output has no reset, so mask it until the first read has landed.
    assign INST       = rd_live_q ? rd_data_q : '0;
    assign INST_VALID = inst_valid_q;
    assign INST_PC    = inst_pc_q;
    assign INST_ERR   = inst_err_q;

endmodule

// File: doc/inst_page_buffer.md
# inst_page_buffer

Instruction page buffer sitting directly downstream of the instruction-fetch AXI reader. It captures the 1024 read-data beats of a 4 KiB page refill (32 bursts × 32 beats × 4 B) into an on-chip 1024×32 RAM, tags the page, and serves instructions to decode with one-cycle latency on a tag hit. On a miss it drops `HIT`, which the fetch stage uses as its page-reload request.

## Interface
- `DATA_WIDTH`, 32: instruction and beat width; only 32 is supported.
- `PAGE_BITS`, 12: log2 of the page size in bytes; word index is `PC[PAGE_BITS-1:2]`, giving 1024 words.
- `BURST_LEN`, 32: beats per burst, used for the `FILL_LAST` check.
- One clock; reset is asynchronous and active-low (`CLK`, `RSTN`).
- `CLK` in 1: clock; all state changes on the rising edge.
- `RSTN` in 1: asynchronous active-low reset.
- `FILL_START` in 1: single-cycle pulse that begins a page refill.
- `FILL_PAGE` in 20: page tag (`PC[31:12]`), latched on `FILL_START`.
- `FILL_VALID` in 1: read-data beat valid (AXI RVALID; RREADY is tied high upstream).
- `FILL_DATA` in 32: beat data (RDATA).
- `FILL_RESP` in 2: beat response (RRESP); any non-zero value is an error.
- `FILL_LAST` in 1: burst last beat (RLAST).
- `FILL_BUSY` out 1: high while in `S_FILL`.
- `FILL_DONE` out 1: one-cycle pulse when the page becomes valid.
- `PC_VALID` in 1: request valid.
- `PC` in 32: fetch address.
- `STALL` in 1: hold all read-side output registers.
- `HIT` out 1: combinational; `PC_VALID && state==S_READY && PC[31:12]==tag`.
- `INST_VALID` out 1: registered; instruction valid.
- `INST` out 32: registered instruction word.
- `INST_PC` out 32: registered PC of `INST`.
- `INST_ERR` out 1: registered; the page had a bus or protocol error, or the PC is misaligned.

## Operation
- States:
  - `S_EMPTY`: the reset state.
  - `S_FILL`: refill in progress.
  - `S_READY`: page valid.
- Any state with `FILL_START`:
  - Go to `S_FILL`.
  - Latch `FILL_PAGE` into the tag.
  - Clear the write pointer (10 bit) and `page_err`.
  - Flush: clear `INST_VALID` next cycle, even under `STALL`.
- In `S_FILL`, each `FILL_VALID` beat:
  - Write `mem[wptr] <= FILL_DATA`, then increment `wptr`.
  - `FILL_RESP != 0` sets `page_err`.
  - `FILL_LAST != (wptr[4:0]==BURST_LEN-1)` sets `page_err`.
- The beat with `wptr==1023` moves the block to `S_READY` and pulses `FILL_DONE` the next cycle. The pointer wraps to 0 and is not used again until the next `FILL_START`.
- `FILL_VALID` outside `S_FILL` is ignored (no write, no error).
- `FILL_START` and `FILL_VALID` in the same cycle: the start wins and the beat is discarded.
- Read path, when `!STALL`:
  - `INST_VALID <= HIT`
  - `INST <= mem[PC[11:2]]`
  - `INST_PC <= PC`
  - `INST_ERR <= HIT && (page_err || PC[1:0]!=0)`
- Read path, when `STALL`: all read outputs hold, except for a `FILL_START` flush.
- On a miss, `INST_VALID` goes low next cycle and `INST`/`INST_PC` still update (don't-care).
- Misaligned PC with a tag hit: `INST_VALID=1`, `INST_ERR=1`, and `INST` is the word at `PC[11:2]`.

## Timing
- Reset values:
  - State `S_EMPTY`, tag valid 0, `page_err` 0, `wptr` 0.
  - `INST_VALID`, `INST`, `INST_PC`, `INST_ERR` = 0.
  - `FILL_BUSY` = 0, `FILL_DONE` = 0; `HIT` = 0.
- `HIT` latency: combinational in the request cycle.
- Instruction latency: one cycle (synchronous-read RAM, inferred as BRAM).
- Refill: with 1024 contiguous beats, `FILL_DONE` asserts one cycle after the final beat.
- First hit: `HIT` can be high the cycle `FILL_DONE` is high; `INST_VALID` rises one cycle later.
- No read-during-write bypass. Reads only hit in `S_READY`, where no writes occur.
- `FILL_BUSY` rises the cycle after `FILL_START` and falls with the `S_READY` transition.
- Reset mid-refill: returns to `S_EMPTY` asynchronously. RAM contents are not cleared, but the tag is invalid.

## Test plan
- Reset, then `PC_VALID=1`, `PC=0x2000_0000` → `HIT=0`, `INST_VALID=0`, `FILL_BUSY=0`.
- `FILL_START` with `FILL_PAGE=0x20000`, then 1024 beats `data=0xA000_0000+i` with `FILL_LAST` every 32nd beat → `FILL_DONE` one cycle after beat 1023. Then `PC=0x2000_0ABC` → `HIT=1`, and next cycle `INST=0xA000_02AF`, `INST_PC=0x2000_0ABC`, `INST_ERR=0`.
- Page loaded, `PC=0x2000_1000` → `HIT=0` and `INST_VALID=0` next cycle. Then `STALL=1` with `PC=0x2000_0004` → outputs held until `STALL` drops.
- Refill with `FILL_RESP=2'b10` on beat 500 → after `FILL_DONE`, any hit gives `INST_VALID=1`, `INST_ERR=1`.
- Refill with `FILL_LAST` missing on beat 31 → `page_err` set and `INST_ERR=1` on hits. Separately, `PC=0x2000_0002` on a clean page → `INST_ERR=1`.
- `FILL_START` mid-refill (beat 600) together with `FILL_VALID` → beat dropped, `wptr=0`, a full 1024 beats are required again.
- `FILL_START` under `STALL` with `INST_VALID=1` → `INST_VALID=0` next cycle.
- `RSTN` low at beat 100 → state `S_EMPTY`, `HIT=0`.
